program_loader: RTL

- Front-end sequencer for the 8-bit CPU core.
- Lets the user key a program byte-by-byte from the switches into the 32x8 program memory, using `enter` as the strobe.
- Holds the core in reset while loading, then releases it to run.
- Watches for `core_done` or a watchdog timeout, and parks the core in a HALT state until the user acknowledges.

---
 rtl/program_loader.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Front-end sequencer for the 8-bit CPU: keys a program into program memory,
// runs the core under a watchdog and parks it in HALT until acknowledged.
module program_loader #(
    parameter int DEPTH           = 32,
    parameter int ADDR_WIDTH      = 5,
    parameter int DATA_WIDTH      = 8,
    parameter int WATCHDOG_CYCLES = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enter,
    input  logic                  start,
    input  logic                  load_mode,
    input  logic [DATA_WIDTH-1:0] switch_data,
    input  logic [ADDR_WIDTH-1:0] core_pc,
    input  logic                  core_done,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_write_enable,
    output logic                  core_reset_n,
    output logic                  core_run,
    output logic [ADDR_WIDTH:0]   load_count,
    output logic                  overflow,
    output logic                  timeout,
    output logic                  halted,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] FULL_COUNT    = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [7:0]          WATCHDOG_LAST = 8'(WATCHDOG_CYCLES - 1);

    state_t                  state_q, state_d;
    logic                    enter_q, start_q;
    logic                    enter_rise, start_rise;
    logic [ADDR_WIDTH-1:0]   write_ptr_q;
    logic [ADDR_WIDTH:0]     load_count_q;
    logic [7:0]              watchdog_q;
    logic                    overflow_q, timeout_q;
    logic                    write_enable_q;
    logic [ADDR_WIDTH-1:0]   write_address_q;
    logic [DATA_WIDTH-1:0]   write_data_q;

    logic do_write, set_overflow, clear_load, start_run, set_timeout;

    assign enter_rise = enter & ~enter_q;
    assign start_rise = start & ~start_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q         <= IDLE;
            enter_q         <= 1'b0;
            start_q         <= 1'b0;
            write_ptr_q     <= '0;
            load_count_q    <= '0;
            watchdog_q      <= '0;
            overflow_q      <= 1'b0;
            timeout_q       <= 1'b0;
            write_enable_q  <= 1'b0;
            write_address_q <= '0;
            write_data_q    <= '0;
        end else begin
            state_q        <= state_d;
            enter_q        <= enter;
            start_q        <= start;
            write_enable_q <= do_write;
            // The address register returns to zero outside a write so IDLE/LOAD present address 0.
            write_address_q <= do_write ? write_ptr_q : '0;
            if (do_write)
                write_data_q <= switch_data;

            if (clear_load) begin
                write_ptr_q  <= '0;
                load_count_q <= '0;
                overflow_q   <= 1'b0;
            end else if (do_write) begin
                write_ptr_q  <= write_ptr_q + ADDR_WIDTH'(1);
                load_count_q <= load_count_q + (ADDR_WIDTH+1)'(1);
            end
            if (set_overflow)
                overflow_q <= 1'b1;

            if (start_run) begin
                watchdog_q <= '0;
                timeout_q  <= 1'b0;
            end else if (state_q == RUN) begin
                watchdog_q <= watchdog_q + 8'd1;
            end
            if (set_timeout)
                timeout_q <= 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        do_write     = 1'b0;
        set_overflow = 1'b0;
        clear_load   = 1'b0;
        start_run    = 1'b0;
        set_timeout  = 1'b0;
        core_reset_n = 1'b0;
        core_run     = 1'b0;
        halted       = 1'b0;
        mem_address  = write_address_q;
        case (state_q)
            IDLE: begin
                if (load_mode) begin
                    state_d    = LOAD;
                    clear_load = 1'b1;
                end else if (start_rise && load_count_q != '0) begin
                    state_d   = RUN;
                    start_run = 1'b1;
                end
            end
            LOAD: begin
                // A strobe in the same cycle load_mode drops still commits its byte.
                if (enter_rise) begin
                    if (load_count_q < FULL_COUNT)
                        do_write = 1'b1;
                    else
                        set_overflow = 1'b1;
                end
                if (!load_mode)
                    state_d = IDLE;
            end
            RUN: begin
                core_reset_n = 1'b1;
                core_run     = 1'b1;
                mem_address  = core_pc;
                if (core_done) begin
                    state_d = HALT;
                end else if (watchdog_q == WATCHDOG_LAST) begin
                    state_d     = HALT;
                    set_timeout = 1'b1;
                end
            end
            HALT: begin
                core_reset_n = 1'b1;
                halted       = 1'b1;
                mem_address  = core_pc;
                if (enter_rise)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_write_data   = write_data_q;
    assign mem_write_enable = write_enable_q;
    assign load_count       = load_count_q;
    assign overflow         = overflow_q;
    assign timeout          = timeout_q;
    assign state            = state_q;

endmodule
